pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage 16-bit pipeline. Drives load-enable and bubble/flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. Handles four cases:
- load-use hazards,
- multi-cycle divide/remainder operations in EX,
- wait-stated data-memory accesses in MEM,
- taken-branch flushes.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states,
// register-specifier width and the NOP control bundle loaded on bubbles.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } hazState_e;

  typedef struct packed {
    logic regWrite;
    logic memToReg;
    logic movOp;
  } ctrlBundle_t;

  localparam ctrlBundle_t CTRL_NOP = '{
    regWrite: 1'b0,
    memToReg: 1'b0,
    movOp:    1'b0
  };

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID source that a load in EX is about to write.
// Ports: ID sources + use bits, EX destination + load flag -> hazard.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = pipe_hazard_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] idRs1,
  input  logic [REG_ADDR_W-1:0] idRs2,
  input  logic                  idUsesRs1,
  input  logic                  idUsesRs2,
  input  logic [REG_ADDR_W-1:0] exRd,
  input  logic                  exMemToReg,
  output logic                  hazard
);

  logic rs1Hit;
  logic rs2Hit;

  assign rs1Hit = idUsesRs1 && (idRs1 == exRd);
  assign rs2Hit = idUsesRs2 && (idRs2 == exRd);

  // r0 is hardwired, so a load targeting it never blocks a reader.
  assign hazard = exMemToReg && (exRd != '0) && (rs1Hit || rs2Hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, divide,
// memory wait and branch flush. Outputs: enables, flush/bubble, div_start.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = pipe_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_is_div,
  input  logic                  div_done,
  output logic                  div_start,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_bubble,
  output logic                  mem_wb_bubble,
  output logic                  mem_error,
  output logic [15:0]           stall_cycles
);

  localparam int CW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  hazState_e     state;
  hazState_e     stateNxt;
  logic [CW-1:0] waitCnt;
  logic          loadUse;
  logic          memWait;
  logic          memHold;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) uHazDet (
    .idRs1     (id_rs1),
    .idRs2     (id_rs2),
    .idUsesRs1 (id_uses_rs1),
    .idUsesRs2 (id_uses_rs2),
    .exRd      (ex_rd),
    .exMemToReg(ex_mem_to_reg),
    .hazard    (loadUse)
  );

  assign memWait = mem_req && !mem_ready;
  // Once waiting, only mem_ready releases the hold.
  assign memHold = memWait ||
                   ((state == MEM_WAIT) && !mem_ready);

  always_comb begin
    stateNxt      = state;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    div_start     = 1'b0;
    if (!rst_n) begin
      stateNxt = RUN;
      {pc_en, if_id_en, id_ex_en,
       ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush,
       ex_mem_bubble, mem_wb_bubble} = '1;
    end else if (state == DIV_WAIT) begin
      if (div_done) begin
        stateNxt = RUN;
      end else begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_bubble = 1'b1;
      end
    end else if (memHold) begin
      // WB keeps clocking but with a NOP so it cannot rewrite.
      stateNxt      = MEM_WAIT;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_is_div) begin
      stateNxt      = DIV_WAIT;
      div_start     = 1'b1;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (loadUse) begin
      stateNxt    = RUN;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      stateNxt = RUN;
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      waitCnt      <= '0;
      mem_error    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= stateNxt;
      if ((state == MEM_WAIT) && !mem_ready) begin
        if (waitCnt != TMO) begin
          waitCnt <= waitCnt + 1'b1;
        end
        if (waitCnt == TMO - 1'b1) begin
          mem_error <= 1'b1;
        end
      end else begin
        waitCnt <= '0;
      end
      if (!pc_en && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_mem_to_reg, ex_is_div, div_done;
  logic       mem_req, mem_ready, branch_taken;
  logic       div_start, pc_en, if_id_en, id_ex_en;
  logic       ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush;
  logic       ex_mem_bubble, mem_wb_bubble, mem_error;
  logic [15:0] stall_cycles;

  int nTests = 0;
  int nFail  = 0;

  // model state
  bit mWait = 0;
  bit dWait = 0;
  bit mErr  = 0;
  int wCnt  = 0;
  int sCnt  = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_W(4),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_is_div    (ex_is_div),
    .div_done     (div_done),
    .div_start    (div_start),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_bubble(mem_wb_bubble),
    .mem_error    (mem_error),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // {pc,ifid,idex,exmem,memwb, ifFl,idFl,exBub,wbBub, divStart}
  localparam logic [9:0] V_RESET = 10'b00000_1111_0;
  localparam logic [9:0] V_RUN   = 10'b11111_0000_0;
  localparam logic [9:0] V_MEMW  = 10'b00001_0001_0;
  localparam logic [9:0] V_DIVS  = 10'b00011_0010_1;
  localparam logic [9:0] V_DIVW  = 10'b00011_0010_0;
  localparam logic [9:0] V_LDUSE = 10'b00111_0100_0;
  localparam logic [9:0] V_BR    = 10'b11111_1100_0;

  function automatic logic [9:0] ctrlObs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_bubble,
            mem_wb_bubble, div_start};
  endfunction

  function automatic logic [9:0] modelCtrl();
    bit hz;
    hz = ex_mem_to_reg && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) ||
          (id_uses_rs2 && id_rs2 == ex_rd));
    if (!rst_n) return V_RESET;
    if (dWait) return div_done ? V_RUN : V_DIVW;
    if ((mWait || mem_req) && !mem_ready) return V_MEMW;
    if (ex_is_div) return V_DIVS;
    if (hz) return V_LDUSE;
    if (branch_taken) return V_BR;
    return V_RUN;
  endfunction

  // Update the model for the coming edge, then move to the next negedge.
  task automatic advance();
    logic [9:0] e;
    e = modelCtrl();
    if (!rst_n) begin
      mWait = 0; dWait = 0; mErr = 0; wCnt = 0; sCnt = 0;
    end else begin
      if (!e[9] && sCnt < 65535) sCnt++;
      if (mWait && !mem_ready) begin
        wCnt++;
        if (wCnt >= TMO) mErr = 1;
      end else begin
        wCnt = 0;
      end
      if (dWait) begin
        dWait = !div_done;
      end else if (!(mWait && !mem_ready)) begin
        mWait = mem_req && !mem_ready;
        dWait = !mWait && ex_is_div;
      end
    end
    @(negedge clk);
  endtask

  task automatic setIdle();
    rst_n = 1; id_rs1 = 1; id_rs2 = 2; ex_rd = 5;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_to_reg = 0;
    ex_is_div = 0; div_done = 0; mem_req = 0;
    mem_ready = 1; branch_taken = 0;
  endtask

  task automatic test_reset();
    setIdle();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      nTests++;
      if (ctrlObs() !== V_RESET) begin
        nFail++;
        $display("FAIL reset_ctrl got %b want %b", ctrlObs(), V_RESET);
      end
      advance();
    end
    rst_n = 1;
    #1;
    nTests++;
    if (ctrlObs() !== V_RUN || mem_error !== 0 || stall_cycles !== 0) begin
      nFail++;
      $display("FAIL reset_state ctrl %b err %b stall %0d want %b 0 0",
               ctrlObs(), mem_error, stall_cycles, V_RUN);
    end
    advance();
  endtask

  task automatic test_load_use();
    logic [9:0] e;
    setIdle();
    ex_mem_to_reg = 1; ex_rd = 3; id_rs2 = 3; id_uses_rs2 = 1;
    #1;
    e = modelCtrl();
    nTests++;
    if (ctrlObs() !== e || pc_en !== 0 || if_id_en !== 0 ||
        id_ex_flush !== 1) begin
      nFail++;
      $display("FAIL ld_use ctrl got %b want %b", ctrlObs(), e);
    end
    advance();
    setIdle();
    #1;
    nTests++;
    if (stall_cycles !== 16'd1 || pc_en !== 1) begin
      nFail++;
      $display("FAIL ld_use_count stall %0d pc_en %b want 1 1",
               stall_cycles, pc_en);
    end
    advance();
    ex_mem_to_reg = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
    id_rs1 = 0; id_uses_rs1 = 1;
    #1;
    nTests++;
    if (ctrlObs() !== V_RUN) begin
      nFail++;
      $display("FAIL ld_use_r0 got %b want %b", ctrlObs(), V_RUN);
    end
    advance();
    ex_rd = 6; id_rs1 = 6; id_uses_rs1 = 0; id_rs2 = 1;
    #1;
    nTests++;
    if (ctrlObs() !== V_RUN) begin
      nFail++;
      $display("FAIL ld_use_unused got %b want %b", ctrlObs(), V_RUN);
    end
    advance();
    setIdle();
  endtask

  task automatic test_divide();
    int starts = 0;
    int lows = 0;
    setIdle();
    for (int i = 0; i < 8; i++) begin
      ex_is_div = (i <= 5);
      div_done  = (i == 5);
      #1;
      nTests++;
      if (ctrlObs() !== modelCtrl()) begin
        nFail++;
        $display("FAIL divide cyc%0d got %b want %b",
                 i, ctrlObs(), modelCtrl());
      end
      starts += int'(div_start);
      lows += int'(!pc_en);
      advance();
    end
    nTests++;
    if (starts != 1 || lows != 5) begin
      nFail++;
      $display("FAIL divide_cost starts %0d lows %0d want 1 5",
               starts, lows);
    end
    setIdle();
  endtask

  task automatic test_mem_wait();
    int frz = 0;
    int bub = 0;
    setIdle();
    for (int i = 0; i < 4; i++) begin
      mem_req = 1; mem_ready = (i == 3);
      #1;
      nTests++;
      if (ctrlObs() !== modelCtrl()) begin
        nFail++;
        $display("FAIL mem_wait cyc%0d got %b want %b",
                 i, ctrlObs(), modelCtrl());
      end
      frz += int'(!pc_en && !if_id_en && !id_ex_en && !ex_mem_en);
      bub += int'(mem_wb_bubble && mem_wb_en);
      if (i == 3) begin
        nTests++;
        if (ctrlObs() !== V_RUN) begin
          nFail++;
          $display("FAIL mem_resume got %b want %b", ctrlObs(), V_RUN);
        end
      end
      advance();
    end
    nTests++;
    if (frz != 3 || bub != 3) begin
      nFail++;
      $display("FAIL mem_cost frz %0d bub %0d want 3 3", frz, bub);
    end
    setIdle();
  endtask

  task automatic test_branch_in_wait();
    int fl = 0;
    setIdle();
    for (int i = 0; i < 4; i++) begin
      mem_req = (i < 3); mem_ready = (i >= 2); branch_taken = (i < 3);
      #1;
      nTests++;
      if (ctrlObs() !== modelCtrl()) begin
        nFail++;
        $display("FAIL br_wait cyc%0d got %b want %b",
                 i, ctrlObs(), modelCtrl());
      end
      if (if_id_flush && id_ex_flush && pc_en) fl++;
      if (i == 2) begin
        nTests++;
        if (ctrlObs() !== V_BR) begin
          nFail++;
          $display("FAIL br_release got %b want %b", ctrlObs(), V_BR);
        end
      end
      advance();
    end
    nTests++;
    if (fl != 1) begin
      nFail++;
      $display("FAIL br_flush_count got %0d want 1", fl);
    end
    setIdle();
  endtask

  task automatic test_timeout();
    setIdle();
    for (int i = 0; i < 12; i++) begin
      mem_req = 1; mem_ready = 0;
      #1;
      nTests++;
      if (mem_error !== (i >= TMO + 1) || ctrlObs() !== V_MEMW) begin
        nFail++;
        $display("FAIL timeout cyc%0d err %b ctrl %b want %b %b",
                 i, mem_error, ctrlObs(), (i >= TMO + 1), V_MEMW);
      end
      advance();
    end
    rst_n = 0;
    #1;
    nTests++;
    if (ctrlObs() !== V_RESET) begin
      nFail++;
      $display("FAIL timeout_rst got %b want %b", ctrlObs(), V_RESET);
    end
    advance();
    setIdle();
    #1;
    nTests++;
    if (mem_error !== 0 || ctrlObs() !== V_RUN) begin
      nFail++;
      $display("FAIL timeout_clr err %b ctrl %b want 0 %b",
               mem_error, ctrlObs(), V_RUN);
    end
    advance();
  endtask

  task automatic test_reset_in_div();
    int starts = 0;
    setIdle();
    for (int i = 0; i < 5; i++) begin
      ex_is_div = (i < 4);
      rst_n = (i != 3);
      #1;
      starts += int'(div_start);
      if (i == 3) begin
        nTests++;
        if (ctrlObs() !== V_RESET) begin
          nFail++;
          $display("FAIL div_rst got %b want %b", ctrlObs(), V_RESET);
        end
      end
      if (i == 4) begin
        nTests++;
        if (ctrlObs() !== V_RUN) begin
          nFail++;
          $display("FAIL div_rst_run got %b want %b", ctrlObs(), V_RUN);
        end
      end
      advance();
    end
    nTests++;
    if (starts != 1) begin
      nFail++;
      $display("FAIL div_rst_starts got %0d want 1", starts);
    end
    setIdle();
  endtask

  task automatic test_random();
    logic [9:0] e;
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(0, 49) != 0);
      id_rs1        = 4'($urandom_range(0, 3));
      id_rs2        = 4'($urandom_range(0, 3));
      ex_rd         = 4'($urandom_range(0, 3));
      id_uses_rs1   = 1'($urandom_range(0, 1));
      id_uses_rs2   = 1'($urandom_range(0, 1));
      ex_mem_to_reg = 1'($urandom_range(0, 1));
      ex_is_div     = ($urandom_range(0, 7) == 0);
      div_done      = ($urandom_range(0, 3) == 0);
      mem_req       = ($urandom_range(0, 2) == 0);
      mem_ready     = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      #1;
      e = modelCtrl();
      nTests++;
      if (ctrlObs() !== e || mem_error !== mErr ||
          stall_cycles !== 16'(sCnt)) begin
        nFail++;
        $display("FAIL random cyc%0d ctrl %b err %b stall %0d want %b %b %0d",
                 i, ctrlObs(), mem_error, stall_cycles, e, mErr, sCnt);
      end
      advance();
    end
    setIdle();
  endtask

  initial begin
    setIdle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait();
    test_branch_in_wait();
    test_timeout();
    test_reset_in_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
